pwm_duty_feeder: RTL and testbench

//  Upstream stage of the PWM generator: buffers 8-bit duty samples arriving on a

---
 rtl/pwm_duty_feeder_pkg.sv | 21 ++
 rtl/pwm_duty_feeder_fifo.sv | 78 +++++++
 rtl/pwm_duty_feeder.sv | 111 +++++++++++
 tb/tb_pwm_duty_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_feeder_pkg.sv
// Shared constants and types for the PWM duty feeder.
// Defaults match the PWM block counter wrap and sample width.
package pwm_duty_feeder_pkg;

    localparam int FDR_DUTY_W    = 8;
    localparam int FDR_PERIOD    = 256;
    localparam int FDR_DEPTH     = 16;
    localparam int FDR_IDLE_DUTY = 0;

    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_SAMPLE,
        LOAD_IDLE,
        LOAD_HOLD
    } load_e;

    function automatic int cnt_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/pwm_duty_feeder_fifo.sv
// Synchronous FIFO with a registered head word for the duty feeder.
// DEPTH must be a power of two; pointers wrap naturally.
module duty_fifo
    import pwm_duty_feeder_pkg::*;
#(
    parameter int W     = FDR_DUTY_W,
    parameter int DEPTH = FDR_DEPTH
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_q;
    logic [W-1:0]  head;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_next = rd_ptr + 1'b1;
    assign count   = count_q;
    assign rd_data = head;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_next;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok)
            mem[wr_ptr] <= wr_data;
    end

    // Head always mirrors the oldest entry; a push landing on an
    // emptying FIFO becomes the new head directly.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            head <= '0;
        end else if (pop_ok) begin
            if (count_q == CW'(1))
                head <= wr_data;
            else
                head <= mem[rd_next];
        end else if (empty && push_ok) begin
            head <= wr_data;
        end
    end

endmodule

// File: rtl/pwm_duty_feeder.sv
// Duty feeder: buffers duty samples, loads one into Dato per PWM period.
// FEEDER_HOLD_LAST_EN: underrun keeps the previous Dato instead of IDLE_DUTY.
module pwm_duty_feeder
    import pwm_duty_feeder_pkg::*;
#(
    parameter int DUTY_W    = FDR_DUTY_W,
    parameter int DEPTH     = FDR_DEPTH,
    parameter int PERIOD    = FDR_PERIOD,
    parameter int IDLE_DUTY = FDR_IDLE_DUTY
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     run,
    input  logic [DUTY_W-1:0]        din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [DUTY_W-1:0]        Dato,
    output logic                     period_start,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     underrun,
    input  logic                     clr_underrun
);

    localparam int CNT_W = cnt_width(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] IDLE_VAL = DUTY_W'(IDLE_DUTY);

    logic [CNT_W-1:0]  cnt;
    logic              boundary;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DUTY_W-1:0] head;
    load_e             load_sel;

    assign din_ready = !full && !reset;
    assign push      = din_valid && din_ready;
    assign boundary  = run && (cnt == CNT_LAST);
    assign pop       = boundary && !empty;

    duty_fifo #(
        .W     (DUTY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (din),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk_in) begin
        if (reset)
            cnt <= '0;
        else if (!run || cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_comb begin
        load_sel = LOAD_NONE;
        if (boundary) begin
            if (!empty)
                load_sel = LOAD_SAMPLE;
            else
`ifdef FEEDER_HOLD_LAST_EN
                load_sel = LOAD_HOLD;
`else
                load_sel = LOAD_IDLE;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            Dato <= IDLE_VAL;
        end else begin
            unique case (load_sel)
                LOAD_SAMPLE: Dato <= head;
                LOAD_IDLE:   Dato <= IDLE_VAL;
                LOAD_HOLD:   Dato <= Dato;
                LOAD_NONE:   Dato <= Dato;
                default:     Dato <= Dato;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset)
            period_start <= 1'b0;
        else
            period_start <= boundary;
    end

    // Setting wins over clearing so a coincident boundary is never lost.
    always_ff @(posedge clk_in) begin
        if (reset)
            underrun <= 1'b0;
        else if (boundary && empty)
            underrun <= 1'b1;
        else if (clr_underrun)
            underrun <= 1'b0;
    end

endmodule

// File: tb/tb_pwm_duty_feeder.sv
// Self-checking bench for pwm_duty_feeder with a queue-based reference model.
// Honours FEEDER_HOLD_LAST_EN when computing underrun expectations.
module tb_pwm_duty_feeder;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [7:0] Dato;
    logic       period_start;
    logic [4:0] fifo_count;
    logic       underrun;
    logic       clr_underrun = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

`ifdef FEEDER_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    always #5 clk_in = ~clk_in;

    pwm_duty_feeder dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .run          (run),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .Dato         (Dato),
        .period_start (period_start),
        .fifo_count   (fifo_count),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    // Reference model: a sample queue, a period position and the output regs.
    logic [7:0] mq[$];
    int         m_pos = 0;
    logic [7:0] m_dato = 8'h00;
    bit         m_ps = 1'b0;
    bit         m_ur = 1'b0;

    always @(posedge clk_in) begin
        bit acc;
        bit bnd;
        if (reset) begin
            mq.delete();
            m_pos  = 0;
            m_dato = 8'h00;
            m_ps   = 1'b0;
            m_ur   = 1'b0;
        end else begin
            acc = din_valid && (mq.size() < 16);
            bnd = run && (m_pos == 255);
            if (bnd) begin
                if (mq.size() > 0) begin
                    m_dato = mq.pop_front();
                end else begin
                    m_ur = 1'b1;
                    if (!HOLD)
                        m_dato = 8'h00;
                end
            end else if (clr_underrun) begin
                m_ur = 1'b0;
            end
            if (acc)
                mq.push_back(din);
            m_ps  = bnd;
            m_pos = run ? (m_pos + 1) % 256 : 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (check_en) begin
            check("dato", Dato, m_dato);
            check("period_start", period_start, m_ps);
            check("fifo_count", fifo_count, mq.size());
            check("underrun", underrun, m_ur);
            check("din_ready", din_ready, !reset && mq.size() < 16);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    task automatic do_reset();
        run = 1'b0;
        din_valid = 1'b0;
        clr_underrun = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] v);
        din = v;
        din_valid = 1'b1;
        tick(1);
        din_valid = 1'b0;
    endtask

    initial begin
        tick(1);
        check_en = 1'b1;
        tick(1);
        reset = 1'b0;

        // idle after reset
        tick(5);
        check("t1_dato", Dato, 8'h00);
        check("t1_ready", din_ready, 1);
        check("t1_count", fifo_count, 0);

        // three samples, one per period
        push_one(8'h10);
        push_one(8'h80);
        push_one(8'hFF);
        run = 1'b1;
        tick(255);
        check("t2_before", Dato, 8'h00);
        tick(1);
        check("t2_d0", Dato, 8'h10);
        check("t2_ps0", period_start, 1);
        tick(1);
        check("t2_ps_off", period_start, 0);
        tick(255);
        check("t2_d1", Dato, 8'h80);
        check("t2_ps1", period_start, 1);
        tick(256);
        check("t2_d2", Dato, 8'hFF);
        check("t2_ps2", period_start, 1);

        // fill to full, 17th push waits for a pop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            din = 8'(i + 1);
            din_valid = 1'b1;
            tick(1);
        end
        check("t3_full_cnt", fifo_count, 16);
        check("t3_full_rdy", din_ready, 0);
        din = 8'hAA;
        run = 1'b1;
        tick(255);
        check("t3_held", fifo_count, 16);
        tick(1);
        check("t3_pop_d", Dato, 8'h01);
        check("t3_pop_cnt", fifo_count, 15);
        check("t3_pop_rdy", din_ready, 1);
        tick(1);
        check("t3_acc_cnt", fifo_count, 16);
        din_valid = 1'b0;

        // underrun and clear
        do_reset();
        push_one(8'h55);
        run = 1'b1;
        tick(256);
        check("t4_load", Dato, 8'h55);
        check("t4_no_ur", underrun, 0);
        tick(256);
        check("t4_ur", underrun, 1);
        check("t4_dato", Dato, HOLD ? 8'h55 : 8'h00);
        clr_underrun = 1'b1;
        tick(1);
        clr_underrun = 1'b0;
        check("t4_clr", underrun, 0);

        // reset mid-period with entries queued
        do_reset();
        for (int i = 0; i < 6; i++)
            push_one(8'(8'h30 + i));
        run = 1'b1;
        tick(256);
        check("t5_load", Dato, 8'h30);
        tick(100);
        reset = 1'b1;
        tick(1);
        check("t5_cnt", fifo_count, 0);
        check("t5_dato", Dato, 8'h00);
        check("t5_ur", underrun, 0);
        reset = 1'b0;
        tick(256);
        check("t5_discard", underrun, 1);

        // drop and re-raise run
        do_reset();
        push_one(8'h21);
        push_one(8'h42);
        run = 1'b1;
        tick(256);
        check("t6_load", Dato, 8'h21);
        tick(50);
        run = 1'b0;
        tick(10);
        check("t6_hold", Dato, 8'h21);
        check("t6_nopop", fifo_count, 1);
        run = 1'b1;
        tick(255);
        check("t6_early", Dato, 8'h21);
        tick(1);
        check("t6_reload", Dato, 8'h42);
        check("t6_ps", period_start, 1);

        tick(2);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
